// File: rtl/rv32_fetch.sv
// Instruction fetch stage: holds the fetch PC, keeps one instruction-memory read in flight,
// and hands {pc, instr, valid} to decode through a one-entry skid buffer with redirect/kill.
module rv32_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_in,
   input  logic        redirect_in,
   input  logic [31:0] redirect_pc_in,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   input  logic        imem_ready_in,
   input  logic        imem_rvalid_in,
   input  logic [31:0] imem_rdata_in,
   output logic        valid_out,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t      state;
   logic [31:0] fetch_pc;
   logic [31:0] issued_pc;
   logic [31:0] buf_pc;
   logic [31:0] buf_instr;
   logic        buf_valid;
   logic        kill;

   logic accept;
   logic deliver;
   logic to_output;
   logic to_buffer;
   logic read_pending;

   assign accept       = (state == REQ) && imem_ready_in;
   assign deliver      = (state == WAIT) && imem_rvalid_in && !kill;
   assign to_output    = deliver && (!valid_out || !stall_in);
   assign to_buffer    = deliver && valid_out && stall_in;
   // A read is still owed to us after this edge if it was just accepted or has not returned yet.
   assign read_pending = accept || ((state == WAIT) && !imem_rvalid_in);

   assign imem_req_out  = (state == REQ);
   assign imem_addr_out = fetch_pc;

   // Fetch FSM, output registers and skid buffer; redirect overrides everything else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         fetch_pc  <= RESET_VECTOR;
         issued_pc <= 32'h0;
         buf_pc    <= 32'h0;
         buf_instr <= 32'h0;
         buf_valid <= 1'b0;
         kill      <= 1'b0;
         valid_out <= 1'b0;
         pc_out    <= 32'h0;
         instr_out <= 32'h0;
      end else if (redirect_in) begin
         fetch_pc  <= redirect_pc_in & ~32'd3;
         valid_out <= 1'b0;
         buf_valid <= 1'b0;
         if (read_pending) begin
            kill  <= 1'b1;
            state <= WAIT;
         end else begin
            kill  <= 1'b0;
            state <= REQ;
         end
      end else begin
         if (to_output) begin
            valid_out <= 1'b1;
            pc_out    <= issued_pc;
            instr_out <= imem_rdata_in;
         end else if (!stall_in) begin
            valid_out <= buf_valid;
            if (buf_valid) begin
               pc_out    <= buf_pc;
               instr_out <= buf_instr;
               buf_valid <= 1'b0;
            end
         end

         if (to_buffer) begin
            buf_pc    <= issued_pc;
            buf_instr <= imem_rdata_in;
            buf_valid <= 1'b1;
         end

         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (imem_ready_in) begin
                  issued_pc <= fetch_pc;
                  fetch_pc  <= fetch_pc + 32'd4;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid_in) begin
                  kill  <= 1'b0;
                  state <= to_buffer ? HOLD : REQ;
               end
            end
            HOLD: begin
               if (!stall_in) state <= REQ;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
